miriscv_instr_mem_responder: RTL
================================

# miriscv_instr_mem_responder

Instruction-memory responder serving the core's fetch-side memory interface. Every cycle it accepts a request (`instr_req_i`, `instr_addr_i`) and returns the addressed word on `instr_rvalid_o`/`instr_rdata_o` after a fixed, parameterised latency, strictly in order. It holds a word-addressed synchronous array, a load port for preloading programs from a bench or debug path, and reports misaligned or out-of-range requests. It is used in simulation and as on-chip instruction RAM in FPGA builds.

## Interface
Parameters:
- `XLEN`, `miriscv_pkg::XLEN` (32): address and data width.
- `MEM_WORDS`, 4096: array depth in words; must be a power of two ≥ 4.
- `LATENCY`, 1: cycles from request to response, legal range 1..4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- `clk_i`  in  1  clock.
- `arstn_i`  in  1  reset, asynchronous, active-low.
- `instr_req_i`  in  1  fetch request valid; no grant, always accepted.
- `instr_addr_i`  in  XLEN  byte address of the request.
- `instr_rvalid_o`  out  1  response valid.
- `instr_rdata_o`  out  XLEN  response word.
- `instr_err_o`  out  1  response is an error; qualified by `instr_rvalid_o`.
- `load_we_i`  in  1  array write enable.
- `load_addr_i`  in  $clog2(MEM_WORDS)  word index for the write.
- `load_wdata_i`  in  XLEN  write data.
- `err_cnt_o`  out  16  count of error responses delivered; saturates at 16'hFFFF.

## Operation
- Offset `off = instr_addr_i - BASE_ADDR`, computed at XLEN width with modular arithmetic. An address below `BASE_ADDR` wraps to a large offset and is therefore out of range.
- A request is misaligned if `instr_addr_i[1:0] != 0`.
- A request is out of range if `off[XLEN-1:2] >= MEM_WORDS`.
- Word index `idx = off[$clog2(MEM_WORDS)+1:2]`.
- Error response: `instr_rdata_o = RV_NOP` (32'h0000_0013) and `instr_err_o = 1`. The array is not read for an error request.
- Valid response: the array word at `idx`, with `instr_err_o = 0`.
- The array is written on the clock edge when `load_we_i = 1`.
- Read-during-write to the same word returns the old data (read-first).
- The load port and the request path operate concurrently. No arbitration is needed.
- Responses are delivered in request order. Back-to-back requests give back-to-back responses, one per cycle, with no bubbles.
- `err_cnt_o` increments on every cycle with `instr_rvalid_o & instr_err_o`, and holds once it reaches 16'hFFFF.

## Timing
- Stage 1: the request is captured at the posedge ending cycle N. This edge performs the synchronous array read and latches the error flag.
- Stages 2..LATENCY: shift registers carrying {valid, err, data}.
- `instr_rvalid_o` is high in exactly cycle N+LATENCY for a request made in cycle N.
- With `LATENCY = 1`, the response appears in the cycle after the request.
- Payload registers load only when a valid beat enters them. `instr_rdata_o` and `instr_err_o` hold their last delivered value while `instr_rvalid_o = 0`.
- Reset values: `instr_rvalid_o = 0`, `instr_rdata_o = 0`, `instr_err_o = 0`, `err_cnt_o = 0`. All pipeline valid bits clear.
- Reset mid-operation: every in-flight response is dropped and never delivered. Array contents are not reset and are retained.
- `instr_req_i = 0` inserts a bubble, and `instr_rvalid_o` is low exactly LATENCY cycles later.
- No flush input exists. The initiator discards stale responses itself.

## Structure
- `miriscv_pkg` additions:
  - `RV_NOP` constant.
  - `LATENCY` range check performed via elaboration-time assertion in the module.
- Sub-module `miriscv_delay_pipe`:
  - Parameters: `DEPTH` and payload `WIDTH`.
  - Carries a valid bit plus payload; payload load is gated by valid; only the valid chain is reset.
  - Instantiated with `DEPTH = LATENCY-1` for stages 2..LATENCY; a pass-through is generated when `DEPTH = 0`.
- Array: an unreset `logic [XLEN-1:0] mem [MEM_WORDS]`, so it infers block RAM.

## Test plan
- Reset: hold `arstn_i = 0` for 3 cycles while `instr_req_i = 1` -> `instr_rvalid_o`, `instr_err_o`, and `err_cnt_o` all stay 0. After release, the first response appears LATENCY cycles after the first request.
- In-order streaming (`LATENCY = 1`): load words 0..3 with 32'h1111_1111..32'h4444_4444, then request addresses 0x0, 0x4, 0x8, 0xC in consecutive cycles N..N+3 -> rvalid in cycles N+1..N+4 with data in that order and `err = 0`.
- Latency (`LATENCY = 3`): request 0x4 in cycle 10, with no request in cycle 11 -> rvalid only in cycle 13 with 32'h2222_2222, and low in cycle 14.
- Errors:
  - Request 0x6 -> `err = 1`, `rdata = 32'h0000_0013`.
  - Request `BASE_ADDR + 4*MEM_WORDS` -> `err = 1`.
  - With `BASE_ADDR = 32'h1000`, request 0x0 -> `err = 1`.
  - After the three errors, `err_cnt_o = 3`.
- Read-during-write: `load_we_i` to word 2 with 32'hDEAD_BEEF in the same cycle as a request to 0x8 -> returns 32'h3333_3333. A request to 0x8 in the next cycle returns 32'hDEAD_BEEF.
- Reset in flight (`LATENCY = 3`): requests in cycles 20 and 21, with `arstn_i` pulsed low in cycle 22 -> no rvalid in cycles 23–24. After reset, a request to 0x0 still returns 32'h1111_1111, showing array contents are retained.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared constants and helpers for the miriscv fetch-side blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package miriscv_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V no-op (addi x0, x0, 0), returned in place of a fetch that faulted.
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/miriscv_delay_pipe.sv
// Valid-qualified delay line: carries a valid bit plus a WIDTH-bit payload through DEPTH register stages.
// Latency: DEPTH cycles; DEPTH = 0 is a combinational pass-through.
// Backpressure: none; every beat advances one stage per cycle.
//
// Ports:
//   clk_i, arstn_i   clock, asynchronous active-low reset (clears the valid chain only)
//   i_vld, i_dat     incoming beat
//   o_vld, o_dat     beat DEPTH cycles later; o_dat holds its last value while o_vld = 0
module miriscv_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = clk_i ^ arstn_i;
            assign o_vld    = i_vld;
            assign o_dat    = i_dat;
        end else begin : g_stages
            logic [DEPTH-1:0] r_vld;
            logic [WIDTH-1:0] r_dat [DEPTH];

            always_ff @(posedge clk_i or negedge arstn_i) begin
                if (!arstn_i) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Payload is unreset and only moves with a valid beat, so a stage
            // keeps the last beat that passed through it.
            always_ff @(posedge clk_i) begin
                if (i_vld) begin
                    r_dat[0] <= i_dat;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (r_vld[i-1]) begin
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign o_vld = r_vld[DEPTH-1];
            assign o_dat = r_dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/miriscv_instr_mem_responder.sv
// Instruction-memory responder: word-addressed synchronous RAM answering fetch requests in order, with a load port.
// Latency: LATENCY cycles (1..4) from request to response, one response per request, no bubbles.
// Backpressure: none; every request is accepted and every response is delivered.
//
// Ports:
//   clk_i, arstn_i                  clock, asynchronous active-low reset
//   instr_req_i, instr_addr_i       fetch request (byte address)
//   instr_rvalid_o, instr_rdata_o   response strobe and word
//   instr_err_o                     response is a misaligned/out-of-range fault (data = RV_NOP)
//   load_we_i/addr_i/wdata_i        array preload port, word indexed, concurrent with fetches
//   err_cnt_o                       saturating count of error responses delivered
module miriscv_instr_mem_responder #(
    parameter int              XLEN      = miriscv_pkg::XLEN,
    parameter int              MEM_WORDS = 4096,
    parameter int              LATENCY   = 1,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         instr_req_i,
    input  logic [XLEN-1:0]              instr_addr_i,
    output logic                         instr_rvalid_o,
    output logic [XLEN-1:0]              instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [XLEN-1:0]              load_wdata_i,
    output logic [15:0]                  err_cnt_o
);

    import miriscv_pkg::*;

    localparam int              AW       = $clog2(MEM_WORDS);
    localparam int              PW       = XLEN + 1;
    localparam logic [XLEN-3:0] LP_WORDS = (XLEN-2)'(MEM_WORDS);
    localparam logic [XLEN-1:0] LP_NOP   = XLEN'(RV_NOP);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("miriscv_instr_mem_responder: LATENCY must be in 1..4");
        end
        if (!is_pow2(MEM_WORDS) || MEM_WORDS < 4) begin : g_bad_depth
            $error("miriscv_instr_mem_responder: MEM_WORDS must be a power of two >= 4");
        end
        if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
            $error("miriscv_instr_mem_responder: BASE_ADDR must be word aligned");
        end
    endgenerate

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic [XLEN-1:0] w_off;
    logic [AW-1:0]   w_idx;
    logic            w_misal;
    logic            w_oor;
    logic            w_err;
    logic            w_rd_en;

    // Modular subtraction: addresses below BASE_ADDR wrap high and fall out of range.
    assign w_off   = instr_addr_i - BASE_ADDR;
    // BASE_ADDR is word aligned, so the offset's low bits equal the address's low bits.
    assign w_misal = |w_off[1:0];
    assign w_oor   = (w_off[XLEN-1:2] >= LP_WORDS);
    assign w_idx   = w_off[AW+1:2];
    assign w_err   = w_misal | w_oor;
    assign w_rd_en = instr_req_i & ~w_err;

    // ---------------------------------------------------------------
    // Array (unreset so it maps onto block RAM) and stage 1
    // ---------------------------------------------------------------
    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [XLEN-1:0] r_rdata;
    logic            r_s1_vld;
    logic            r_s1_err;
    logic [XLEN-1:0] w_s1_dat;

    // Write and registered read share one block: the read sees the pre-edge word (read-first).
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
        if (w_rd_en) begin
            r_rdata <= mem[w_idx];
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= instr_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (instr_req_i) begin
            r_s1_err <= w_err;
        end
    end

    // Faulted requests skip the array read; r_rdata keeps stale data that the mux hides.
    assign w_s1_dat = r_s1_err ? LP_NOP : r_rdata;

    // ---------------------------------------------------------------
    // Stages 2..LATENCY
    // ---------------------------------------------------------------
    logic          w_out_vld;
    logic [PW-1:0] w_out_pld;
    logic          w_out_err;
    logic [XLEN-1:0] w_out_dat;

    miriscv_delay_pipe #(
        .DEPTH (LATENCY - 1),
        .WIDTH (PW)
    ) u_delay_pipe (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .i_vld   (r_s1_vld),
        .i_dat   ({r_s1_err, w_s1_dat}),
        .o_vld   (w_out_vld),
        .o_dat   (w_out_pld)
    );

    assign {w_out_err, w_out_dat} = w_out_pld;

    // ---------------------------------------------------------------
    // Output qualification and error counter
    // ---------------------------------------------------------------
    // Payload registers are unreset. r_dlvd records that a beat has been delivered
    // since reset; until then the payload outputs read zero, afterwards they hold
    // the last delivered beat.
    logic        r_dlvd;
    logic [15:0] r_err_cnt;
    logic        w_show;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_dlvd    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_out_vld) begin
                r_dlvd <= 1'b1;
            end
            if (w_out_vld && w_out_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign w_show         = w_out_vld | r_dlvd;
    assign instr_rvalid_o = w_out_vld;
    assign instr_rdata_o  = w_show ? w_out_dat : '0;
    assign instr_err_o    = w_show & w_out_err;
    assign err_cnt_o      = r_err_cnt;

endmodule
